// File: rtl/branch_outcome_checker.sv
// In-order branch outcome checker: expected records are queued and compared, in order,
// against EX-stage branch resolutions, with pass/fail/spurious counting and a timeout.
module branch_outcome_checker #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             chk_enable,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic             exp_taken,
  input  logic [XLEN-1:0]  exp_target,
  input  logic [XLEN-1:0]  exp_op1,
  input  logic [XLEN-1:0]  exp_op2,
  input  logic             ex_branch_valid,
  input  logic             ex_branch_taken,
  input  logic [XLEN-1:0]  ex_branch_target,
  input  logic [XLEN-1:0]  ex_op1,
  input  logic [XLEN-1:0]  ex_op2,
  output logic             err_valid,
  output logic [4:0]       err_code,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] spurious_cnt,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ARMED = 2'd2
  } state_e;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
  } rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              full_q, full_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              err_valid_q, err_valid_d;
  logic [4:0]        err_code_q, err_code_d;
  logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d, spur_q, spur_d;
  rec_t              mem_q [DEPTH];

  rec_t              head_s;
  logic              push_s, pop_s, empty_d;
  logic [4:0]        mismatch_s;

  // Record storage; only written on an accepted push, so no reset is needed.
  always_ff @(posedge Clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= '{taken: exp_taken, target: exp_target, op1: exp_op1, op2: exp_op2};
    end
  end

  // Next-state, queue bookkeeping, compare and counter updates.
  always_comb begin
    head_s      = mem_q[rd_ptr_q];
    push_s      = exp_valid && !full_q;
    pop_s       = 1'b0;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    spur_d      = spur_q;

    mismatch_s    = 5'b00000;
    mismatch_s[0] = head_s.taken != ex_branch_taken;
    mismatch_s[1] = head_s.taken && ex_branch_taken && (head_s.target != ex_branch_target);
    mismatch_s[2] = (head_s.op1 != ex_op1) || (head_s.op2 != ex_op2);

    case (state_q)
      S_ARMED: begin
        if (ex_branch_valid) begin
          pop_s = 1'b1;
          if (|mismatch_s) begin
            fail_d      = sat_inc(fail_q);
            err_valid_d = 1'b1;
            err_code_d  = mismatch_s;
          end else begin
            pass_d = sat_inc(pass_q);
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          pop_s       = 1'b1;
          fail_d      = sat_inc(fail_q);
          err_valid_d = 1'b1;
          err_code_d  = 5'b01000;
        end else begin
          pop_s = 1'b0;
        end
      end
      S_WAIT: begin
        if (ex_branch_valid) begin
          spur_d      = sat_inc(spur_q);
          err_valid_d = 1'b1;
          err_code_d  = 5'b10000;
        end else begin
          spur_d = spur_q;
        end
      end
      default: begin
        pop_s = 1'b0;
      end
    endcase

    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    if (push_s && !pop_s) begin
      full_d = (wr_ptr_d == rd_ptr_q);
    end else if (pop_s && !push_s) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
    empty_d = (wr_ptr_d == rd_ptr_d) && !full_d;

    if (!chk_enable) begin
      state_d = S_IDLE;
    end else if (empty_d) begin
      state_d = S_WAIT;
    end else begin
      state_d = S_ARMED;
    end

    // Timer only runs across consecutive ARMED cycles with no pop.
    if ((state_q == S_ARMED) && (state_d == S_ARMED) && !pop_s) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = '0;
    end
  end

  // State, queue pointers, timer and result registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      full_q      <= 1'b0;
      timer_q     <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 5'b00000;
      pass_q      <= '0;
      fail_q      <= '0;
      spur_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      full_q      <= full_d;
      timer_q     <= timer_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      spur_q      <= spur_d;
    end
  end

  assign exp_ready    = !full_q;
  assign err_valid    = err_valid_q;
  assign err_code     = err_code_q;
  assign pass_cnt     = pass_q;
  assign fail_cnt     = fail_q;
  assign spurious_cnt = spur_q;
  assign done         = (state_q == S_WAIT);

endmodule

// File: tb/tb_branch_outcome_checker.sv
// Bench for branch_outcome_checker: directed cases with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_branch_outcome_checker;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 32;
  localparam int CMAX    = 65535;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        chk_enable = 1'b0, exp_valid = 1'b0, exp_taken = 1'b0;
  logic [31:0] exp_target = 32'd0, exp_op1 = 32'd0, exp_op2 = 32'd0;
  logic        ex_branch_valid = 1'b0, ex_branch_taken = 1'b0;
  logic [31:0] ex_branch_target = 32'd0, ex_op1 = 32'd0, ex_op2 = 32'd0;
  logic        exp_ready, err_valid, done;
  logic [4:0]  err_code;
  logic [15:0] pass_cnt, fail_cnt, spurious_cnt;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  branch_outcome_checker #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(16), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .chk_enable(chk_enable),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_taken(exp_taken),
    .exp_target(exp_target), .exp_op1(exp_op1), .exp_op2(exp_op2),
    .ex_branch_valid(ex_branch_valid), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .err_valid(err_valid), .err_code(err_code), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .spurious_cnt(spurious_cnt), .done(done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          taken;
    logic [31:0] tgt;
    logic [31:0] op1;
    logic [31:0] op2;
  } rec_t;

  // Reference model: pending records, counters and the last error.
  rec_t       m_q[$];
  bit         m_en_prev;
  int         m_timer, m_pass, m_fail, m_spur;
  bit         m_err_v;
  logic [4:0] m_err_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_q.delete();
      m_en_prev = 1'b0; m_timer = 0; m_pass = 0; m_fail = 0; m_spur = 0;
      m_err_v = 1'b0; m_err_code = 5'b00000;
    end else begin
      automatic int   sz0 = m_q.size();
      automatic bit   armed = m_en_prev && (sz0 > 0);
      automatic bit   waiting = m_en_prev && (sz0 == 0);
      automatic bit   popped = 1'b0;
      automatic rec_t h;
      automatic logic [4:0] code = 5'b00000;
      m_err_v = 1'b0;
      if (armed && ex_branch_valid) begin
        h = m_q.pop_front();
        popped = 1'b1;
        if (h.taken != ex_branch_taken) code[0] = 1'b1;
        if (h.taken && ex_branch_taken && h.tgt != ex_branch_target) code[1] = 1'b1;
        if (h.op1 != ex_op1 || h.op2 != ex_op2) code[2] = 1'b1;
        if (code != 5'b00000) begin
          if (m_fail < CMAX) m_fail++;
          m_err_v = 1'b1; m_err_code = code;
        end else if (m_pass < CMAX) m_pass++;
      end else if (armed && m_timer == TIMEOUT - 1) begin
        void'(m_q.pop_front());
        popped = 1'b1;
        if (m_fail < CMAX) m_fail++;
        m_err_v = 1'b1; m_err_code = 5'b01000;
      end else if (waiting && ex_branch_valid) begin
        if (m_spur < CMAX) m_spur++;
        m_err_v = 1'b1; m_err_code = 5'b10000;
      end
      if (exp_valid && sz0 < DEPTH)
        m_q.push_back('{taken: exp_taken, tgt: exp_target, op1: exp_op1, op2: exp_op2});
      m_timer = (armed && !popped && chk_enable && m_q.size() > 0) ? m_timer + 1 : 0;
      m_en_prev = chk_enable;
    end
  end

  // Single compare process: every live cycle, mid-way between active edges.
  always @(negedge Clk) begin
    if (Reset_n && cmp_on) begin
      chk("pass_cnt", 32'(pass_cnt), 32'(m_pass));
      chk("fail_cnt", 32'(fail_cnt), 32'(m_fail));
      chk("spurious_cnt", 32'(spurious_cnt), 32'(m_spur));
      chk("err_valid", 32'(err_valid), 32'(m_err_v));
      chk("err_code", 32'(err_code), 32'(m_err_code));
      chk("exp_ready", 32'(exp_ready), 32'(m_q.size() < DEPTH));
      chk("done", 32'(done), 32'(m_en_prev && m_q.size() == 0));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic clear_in();
    exp_valid = 1'b0;
    ex_branch_valid = 1'b0;
  endtask

  task automatic push(input bit t, input logic [31:0] tg, input logic [31:0] a, input logic [31:0] b);
    exp_valid = 1'b1; exp_taken = t; exp_target = tg; exp_op1 = a; exp_op2 = b;
  endtask

  task automatic resolve(input bit t, input logic [31:0] tg, input logic [31:0] a, input logic [31:0] b);
    ex_branch_valid = 1'b1; ex_branch_taken = t; ex_branch_target = tg; ex_op1 = a; ex_op2 = b;
  endtask

  initial begin
    #12;
    chk("rst_pass", 32'(pass_cnt), 32'd0);
    chk("rst_fail", 32'(fail_cnt), 32'd0);
    chk("rst_spur", 32'(spurious_cnt), 32'd0);
    chk("rst_errv", 32'(err_valid), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(exp_ready), 32'd1);
    Reset_n = 1'b1;
    cmp_on = 1'b1;
    tick();

    // Matching record passes.
    chk_enable = 1'b1;
    push(1'b1, 32'h14, 32'h1234, 32'h1234); tick(); clear_in();
    resolve(1'b1, 32'h14, 32'h1234, 32'h1234); tick(); clear_in();
    chk("t1_pass", 32'(pass_cnt), 32'd1);
    chk("t1_fail", 32'(fail_cnt), 32'd0);
    chk("t1_errv", 32'(err_valid), 32'd0);

    // Operand mismatch.
    push(1'b1, 32'h30, 32'd5, 32'd7); tick(); clear_in();
    resolve(1'b1, 32'h30, 32'd5, 32'd6); tick(); clear_in();
    chk("t2_fail", 32'(fail_cnt), 32'd1);
    chk("t2_code", 32'(err_code), 32'h04);
    chk("t2_errv", 32'(err_valid), 32'd1);
    tick();
    chk("t2_pulse", 32'(err_valid), 32'd0);

    // Direction then target mismatch.
    push(1'b1, 32'h20, 32'd1, 32'd2); tick(); clear_in();
    resolve(1'b0, 32'h24, 32'd1, 32'd2); tick(); clear_in();
    chk("t3_dir", 32'(err_code), 32'h01);
    push(1'b1, 32'h20, 32'd1, 32'd2); tick(); clear_in();
    resolve(1'b1, 32'h24, 32'd1, 32'd2); tick(); clear_in();
    chk("t3_tgt", 32'(err_code), 32'h02);
    chk("t3_fail", 32'(fail_cnt), 32'd3);

    // Timeout after TIMEOUT armed cycles.
    push(1'b0, 32'h0, 32'd9, 32'd9); tick(); clear_in();
    repeat (TIMEOUT - 1) tick();
    chk("t4_pre", 32'(fail_cnt), 32'd3);
    tick();
    chk("t4_fail", 32'(fail_cnt), 32'd4);
    chk("t4_code", 32'(err_code), 32'h08);
    chk("t4_done", 32'(done), 32'd1);

    // Resolution on the expiry cycle wins.
    push(1'b0, 32'h0, 32'd3, 32'd4); tick(); clear_in();
    repeat (TIMEOUT - 1) tick();
    resolve(1'b0, 32'h8, 32'd3, 32'd4); tick(); clear_in();
    chk("t5_pass", 32'(pass_cnt), 32'd2);
    chk("t5_fail", 32'(fail_cnt), 32'd4);
    chk("t5_code", 32'(err_code), 32'h08);

    // Fill the queue, drop a push while full, then drain with wrap.
    for (int i = 0; i < DEPTH; i++) begin
      push(i[0], 32'h100 + 32'(i * 4), 32'(i), ~32'(i)); tick();
    end
    chk("t6_full", 32'(exp_ready), 32'd0);
    push(1'b1, 32'hdead, 32'hbeef, 32'hcafe); tick(); clear_in();
    for (int i = 0; i < DEPTH; i++) begin
      resolve(i[0], 32'h100 + 32'(i * 4), 32'(i), ~32'(i)); tick();
    end
    clear_in();
    chk("t6_pass", 32'(pass_cnt), 32'd10);
    chk("t6_done", 32'(done), 32'd1);
    resolve(1'b1, 32'hdead, 32'hbeef, 32'hcafe); tick(); clear_in();
    chk("t6_spur", 32'(spurious_cnt), 32'd1);
    chk("t6_code", 32'(err_code), 32'h10);

    // Reset with records pending, then disabled resolutions do nothing.
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 32'(i), 32'(i), 32'(i)); tick();
    end
    clear_in();
    chk_enable = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk("t7_pass", 32'(pass_cnt), 32'd0);
    chk("t7_fail", 32'(fail_cnt), 32'd0);
    chk("t7_spur", 32'(spurious_cnt), 32'd0);
    chk("t7_ready", 32'(exp_ready), 32'd1);
    #1;
    Reset_n = 1'b1;
    repeat (5) begin
      resolve(1'b1, 32'h4, 32'd1, 32'd1); tick();
    end
    clear_in();
    chk("t8_pass", 32'(pass_cnt), 32'd0);
    chk("t8_spur", 32'(spurious_cnt), 32'd0);
    chk("t8_done", 32'(done), 32'd0);

    // Randomized traffic with phases of varying resolution density.
    chk_enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      automatic int pct = (c / 250) % 4 == 1 ? 0 : ((c / 250) % 4 == 2 ? 60 : 25);
      if (chk_enable && $urandom_range(99) < 2) chk_enable = 1'b0;
      else if (!chk_enable && $urandom_range(99) < 30) chk_enable = 1'b1;
      exp_valid  = $urandom_range(99) < 35;
      exp_taken  = 1'($urandom);
      exp_target = $urandom; exp_op1 = $urandom; exp_op2 = $urandom;
      ex_branch_valid = $urandom_range(99) < pct;
      if (m_q.size() > 0 && $urandom_range(9) != 0) begin
        ex_branch_taken = m_q[0].taken; ex_branch_target = m_q[0].tgt;
        ex_op1 = m_q[0].op1; ex_op2 = m_q[0].op2;
        if ($urandom_range(4) == 0) begin
          case ($urandom_range(3))
            0: ex_branch_taken = ~ex_branch_taken;
            1: ex_branch_target = ex_branch_target ^ 32'h4;
            2: ex_op1 = ex_op1 + 32'd1;
            default: ex_op2 = ex_op2 ^ 32'h80000000;
          endcase
        end
      end else begin
        ex_branch_taken = 1'($urandom); ex_branch_target = $urandom;
        ex_op1 = $urandom; ex_op2 = $urandom;
      end
      tick();
    end
    clear_in();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
